// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding, forward-select codes and the register-index width helper.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FLUSH    = 2'd2
   } hz_state_e;

   localparam logic [1:0] FWD_RF    = 2'd0;
   localparam logic [1:0] FWD_EXMEM = 2'd1;
   localparam logic [1:0] FWD_MEMWB = 2'd2;

   // Register index width; never narrower than one bit.
   function automatic int hz_aw(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hz_scoreboard.sv
// Outstanding-load scoreboard: one bit per architectural register, set when
// a load is accepted out of decode and cleared when it writes back.
// Register 0 is never tracked. Lookups see a same-cycle writeback clear.
module hz_scoreboard
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter  int NREG = 16,
   localparam int AW   = hz_aw(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            set_en,
   input  logic [AW-1:0]   set_idx,
   input  logic            clr_en,
   input  logic [AW-1:0]   clr_idx,
   input  logic [2*AW-1:0] rd_idx,
   output logic [1:0]      pend
);

   logic [NREG-1:0] sb_q;
   logic [NREG-1:0] sb_d;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;

   // Next scoreboard value; a set beats a clear of the same register.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en) set_mask[set_idx] = 1'b1;
      if (clr_en) clr_mask[clr_idx] = 1'b1;
      sb_d    = (sb_q & ~clr_mask) | set_mask;
      sb_d[0] = 1'b0;
   end

   // Scoreboard register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) sb_q <= '0;
      else      sb_q <= sb_d;
   end

   // Per-source lookup, masked by a writeback retiring that register now.
   always_comb begin
      pend = '0;
      for (int i = 0; i < 2; i++) begin
         pend[i] = sb_q[rd_idx[i*AW +: AW]] &&
                   !(clr_en && (clr_idx == rd_idx[i*AW +: AW]));
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, operand forwarding select,
// memory-wait freeze and redirect flush sequencing.
// Build option: define HAZ_FWD_EN to enable EX/MEM and MEM/WB forwarding;
// without it fwd_sel stays 0 and any in-flight writer of a source stalls.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | normal flow; hazards stall, redirect flushes
// ST_MEM_WAIT | data memory outstanding; whole pipe frozen, redirect held
// ST_FLUSH    | extra flush cycles after a redirect, counted down in cnt_q
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter  int NREG      = 16,
   parameter  int FLUSH_CYC = 2,
   localparam int AW        = hz_aw(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            d_valid,
   input  logic [2*AW-1:0] d_rs,
   input  logic [1:0]      d_rs_use,
   input  logic [AW-1:0]   d_rd,
   input  logic            d_wen,
   input  logic            d_load,
   input  logic [AW-1:0]   e_rd,
   input  logic            e_wen,
   input  logic            e_load,
   input  logic [AW-1:0]   m_rd,
   input  logic            m_wen,
   input  logic [AW-1:0]   w_rd,
   input  logic            w_wen,
   input  logic            w_load,
   input  logic            redirect,
   input  logic            dmem_req,
   input  logic            dmem_ready,
   output logic            pc_stall,
   output logic            ifid_stall,
   output logic            idex_bubble,
   output logic            flush,
   output logic [3:0]      fwd_sel,
   output logic            busy
);

   localparam logic [1:0] FLUSH_RLD = 2'(FLUSH_CYC - 1);

   hz_state_e   state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        pend_q, pend_d;

   logic [AW-1:0] rs [2];
   logic [1:0]    sb_pend;
   logic [1:0]    src_haz;
   logic [3:0]    fwd_raw;
   logic          haz;
   logic          mem_stall;
   logic          busy_c, stall_c, bubble_c, flush_c;
   logic          sb_set;

   assign rs[0] = d_rs[AW-1:0];
   assign rs[1] = d_rs[2*AW-1:AW];

   hz_scoreboard #(.NREG(NREG)) u_sb (
      .clk     (clk),
      .rst     (rst),
      .set_en  (sb_set),
      .set_idx (d_rd),
      .clr_en  (w_load && w_wen),
      .clr_idx (w_rd),
      .rd_idx  (d_rs),
      .pend    (sb_pend)
   );

   // Per-source hazard and forward selection; register 0 never participates.
   // A load sitting in MEM always has its scoreboard bit set, so it stalls
   // and the EX/MEM forward below is only ever used for non-load results.
   always_comb begin
      src_haz = '0;
      fwd_raw = '0;
      for (int i = 0; i < 2; i++) begin
         if (d_valid && d_rs_use[i] && (rs[i] != '0)) begin
            src_haz[i] = sb_pend[i] || (e_load && e_wen && (e_rd == rs[i]));
`ifndef HAZ_FWD_EN
            if ((e_wen && (e_rd == rs[i])) || (m_wen && (m_rd == rs[i])) ||
                (w_wen && (w_rd == rs[i])))
               src_haz[i] = 1'b1;
`endif
         end
`ifdef HAZ_FWD_EN
         if (rs[i] != '0) begin
            if (m_wen && (m_rd == rs[i]))      fwd_raw[2*i +: 2] = FWD_EXMEM;
            else if (w_wen && (w_rd == rs[i])) fwd_raw[2*i +: 2] = FWD_MEMWB;
         end
`endif
      end
   end

   assign haz       = |src_haz;
   assign mem_stall = dmem_req && !dmem_ready;

   // FSM next state and combinational control. The dmem_ready cycle of a
   // memory wait behaves like IDLE, with any held redirect applied then.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      busy_c   = 1'b0;
      stall_c  = 1'b0;
      bubble_c = 1'b0;
      flush_c  = 1'b0;
      case (state_q)
         ST_FLUSH: begin
            flush_c = 1'b1;
            if (redirect) begin
               cnt_d = FLUSH_RLD;
            end else if (cnt_q <= 2'd1) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ST_MEM_WAIT: begin
            if (!dmem_ready) begin
               busy_c  = 1'b1;
               stall_c = 1'b1;
               if (redirect) pend_d = 1'b1;
            end else begin
               pend_d  = 1'b0;
               state_d = ST_IDLE;
               if (redirect || pend_q) begin
                  flush_c = 1'b1;
                  cnt_d   = FLUSH_RLD;
                  state_d = (FLUSH_CYC > 1) ? ST_FLUSH : ST_IDLE;
               end else if (haz) begin
                  stall_c  = 1'b1;
                  bubble_c = 1'b1;
               end
            end
         end
         default: begin
            if (mem_stall) begin
               busy_c  = 1'b1;
               stall_c = 1'b1;
               pend_d  = redirect;
               state_d = ST_MEM_WAIT;
            end else if (redirect) begin
               flush_c = 1'b1;
               cnt_d   = FLUSH_RLD;
               state_d = (FLUSH_CYC > 1) ? ST_FLUSH : ST_IDLE;
            end else if (haz) begin
               stall_c  = 1'b1;
               bubble_c = 1'b1;
            end
         end
      endcase
   end

   assign sb_set = d_valid && d_load && d_wen && (d_rd != '0) &&
                   !stall_c && !flush_c;

   // State, flush counter and held-redirect registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   // Outputs forced low while reset is held.
   assign pc_stall    = rst && stall_c;
   assign ifid_stall  = rst && stall_c;
   assign idex_bubble = rst && bubble_c;
   assign flush       = rst && flush_c;
   assign busy        = rst && busy_c;
   assign fwd_sel     = rst ? fwd_raw : 4'd0;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic, all
// checked against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;
   localparam int NREG      = 16;
   localparam int FLUSH_CYC = 2;
   localparam int AW        = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            d_valid;
   logic [2*AW-1:0] d_rs;
   logic [1:0]      d_rs_use;
   logic [AW-1:0]   d_rd;
   logic            d_wen, d_load;
   logic [AW-1:0]   e_rd;
   logic            e_wen, e_load;
   logic [AW-1:0]   m_rd;
   logic            m_wen;
   logic [AW-1:0]   w_rd;
   logic            w_wen, w_load;
   logic            redirect, dmem_req, dmem_ready;
   logic            pc_stall, ifid_stall, idex_bubble, flush, busy;
   logic [3:0]      fwd_sel;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.NREG(NREG), .FLUSH_CYC(FLUSH_CYC)) dut (
      .clk(clk), .rst(rst),
      .d_valid(d_valid), .d_rs(d_rs), .d_rs_use(d_rs_use),
      .d_rd(d_rd), .d_wen(d_wen), .d_load(d_load),
      .e_rd(e_rd), .e_wen(e_wen), .e_load(e_load),
      .m_rd(m_rd), .m_wen(m_wen),
      .w_rd(w_rd), .w_wen(w_wen), .w_load(w_load),
      .redirect(redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_bubble(idex_bubble),
      .flush(flush), .fwd_sel(fwd_sel), .busy(busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: which registers await a load, memory-wait flag, held
   // redirect, and how many more cycles flush must stay high.
   bit pend_load [NREG];
   bit waiting;
   bit redir_pend;
   int flush_left;

   bit x_stall, x_bubble, x_flush, x_busy;
   int x_fwd;

   int busy_seen, flush_seen;
   logic       o_stall, o_flush;
   logic [3:0] o_fwd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_eval();
      bit hz;
      int src;
      int sel;
      x_stall = 0; x_bubble = 0; x_flush = 0; x_busy = 0; x_fwd = 0;
      if (rst) begin
         hz = 0;
         for (int i = 0; i < 2; i++) begin
            src = (int'(d_rs) >> (AW*i)) & (NREG-1);
            if (src != 0) begin
               if (d_valid && d_rs_use[i]) begin
                  if (pend_load[src] && !(w_load && w_wen && w_rd == src)) hz = 1;
                  if (e_load && e_wen && e_rd == src) hz = 1;
`ifndef HAZ_FWD_EN
                  if ((e_wen && e_rd == src) || (m_wen && m_rd == src) ||
                      (w_wen && w_rd == src)) hz = 1;
`endif
               end
`ifdef HAZ_FWD_EN
               sel = 0;
               if (w_wen && w_rd == src) sel = 2;
               if (m_wen && m_rd == src) sel = 1;
               x_fwd += sel << (2*i);
`endif
            end
         end
         if (flush_left > 0) x_flush = 1;
         else if (!dmem_ready && (waiting || dmem_req)) begin
            x_busy = 1; x_stall = 1;
         end else if (redirect || (waiting && redir_pend)) x_flush = 1;
         else if (hz) begin
            x_stall = 1; x_bubble = 1;
         end
      end
   endtask

   task automatic model_update();
      if (!rst) begin
         foreach (pend_load[r]) pend_load[r] = 0;
         waiting = 0; redir_pend = 0; flush_left = 0;
      end else begin
         if (w_load && w_wen) pend_load[w_rd] = 0;
         if (d_valid && d_load && d_wen && d_rd != 0 && !x_stall && !x_flush)
            pend_load[d_rd] = 1;
         if (flush_left > 0) flush_left = redirect ? FLUSH_CYC - 1 : flush_left - 1;
         else if (x_busy) begin
            waiting = 1;
            if (redirect) redir_pend = 1;
         end else begin
            waiting = 0; redir_pend = 0;
            if (x_flush) flush_left = FLUSH_CYC - 1;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      model_eval();
      chk("pc_stall",    pc_stall,    x_stall);
      chk("ifid_stall",  ifid_stall,  x_stall);
      chk("idex_bubble", idex_bubble, x_bubble);
      chk("flush",       flush,       x_flush);
      chk("busy",        busy,        x_busy);
      chk("fwd_sel",     fwd_sel,     x_fwd);
      busy_seen  += int'(busy === 1'b1);
      flush_seen += int'(flush === 1'b1);
      o_stall = pc_stall;
      o_flush = flush;
      o_fwd   = fwd_sel;
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic clr_in();
      rst = 1'b1;
      d_valid = 0; d_rs = '0; d_rs_use = '0; d_rd = '0; d_wen = 0; d_load = 0;
      e_rd = '0; e_wen = 0; e_load = 0;
      m_rd = '0; m_wen = 0;
      w_rd = '0; w_wen = 0; w_load = 0;
      redirect = 0; dmem_req = 0; dmem_ready = 1;
   endtask

   initial begin
      clr_in();
      rst = 1'b0;
      cycle();
      cycle();
      clr_in();
      cycle();

      // Load R3 in EX, consumer of R3 in decode: one stall, then R3 from WB.
      clr_in();
      e_load = 1; e_wen = 1; e_rd = 3;
      d_valid = 1; d_rs = {4'd1, 4'd3}; d_rs_use = 2'b11; d_rd = 4; d_wen = 1;
      cycle();
      chk("lw_use_stall", o_stall, 1);
      e_load = 0; e_wen = 0; e_rd = 0;
      w_load = 1; w_wen = 1; w_rd = 3;
      cycle();
`ifdef HAZ_FWD_EN
      chk("lw_use_fwd_a", o_fwd[1:0], 2);
      chk("lw_use_nostall", o_stall, 0);
`endif

      // ALU result R5 in MEM used as rs2; then the same pattern on R0.
      clr_in();
      m_wen = 1; m_rd = 5;
      d_valid = 1; d_rs = {4'd5, 4'd2}; d_rs_use = 2'b11;
      cycle();
`ifdef HAZ_FWD_EN
      chk("exmem_fwd_b", o_fwd[3:2], 1);
      chk("exmem_nostall", o_stall, 0);
`endif
      m_rd = 0; d_rs = {4'd0, 4'd2};
      cycle();
      chk("r0_fwd", o_fwd, 0);
      chk("r0_nostall", o_stall, 0);

      // Memory wait: ready low for three cycles.
      clr_in();
      busy_seen = 0;
      dmem_req = 1; dmem_ready = 0;
      for (int k = 0; k < 3; k++) cycle();
      dmem_ready = 1;
      cycle();
      clr_in();
      cycle();
      chk("busy_cycles", busy_seen, 3);

      // Redirect from IDLE, then a redirect held across a memory wait.
      clr_in();
      flush_seen = 0;
      redirect = 1;
      cycle();
      redirect = 0;
      for (int k = 0; k < 3; k++) cycle();
      chk("flush_cycles", flush_seen, FLUSH_CYC);
      dmem_req = 1; dmem_ready = 0; redirect = 1;
      cycle();
      chk("mw_no_flush", o_flush, 0);
      redirect = 0;
      cycle();
      flush_seen = 0;
      dmem_ready = 1;
      cycle();
      chk("mw_flush_on_ready", o_flush, 1);
      clr_in();
      for (int k = 0; k < 3; k++) cycle();
      chk("mw_flush_cycles", flush_seen, FLUSH_CYC);

      // Load to R7 pending, reset during FLUSH clears it.
      clr_in();
      d_valid = 1; d_load = 1; d_wen = 1; d_rd = 7;
      cycle();
      clr_in();
      d_valid = 1; d_rs = {4'd0, 4'd7}; d_rs_use = 2'b01;
      cycle();
      chk("r7_pending_stall", o_stall, 1);
      clr_in();
      redirect = 1;
      cycle();
      redirect = 0;
      rst = 0;
      d_valid = 1; d_rs = {4'd0, 4'd7}; d_rs_use = 2'b01;
      dmem_req = 1; dmem_ready = 0;
      cycle();
      chk("rst_outputs_zero", {pc_stall, ifid_stall, idex_bubble, flush, busy, fwd_sel}, 0);
      clr_in();
      d_valid = 1; d_rs = {4'd0, 4'd7}; d_rs_use = 2'b01;
      cycle();
      chk("r7_after_rst", o_stall, 0);

      // Random traffic over a small register window to force collisions.
      for (int k = 0; k < 3000; k++) begin
         rst        = ($urandom_range(0, 99) != 0);
         d_valid    = 1'($urandom_range(0, 1));
         d_rs       = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
         d_rs_use   = 2'($urandom_range(0, 3));
         d_rd       = 4'($urandom_range(0, 7));
         d_wen      = 1'($urandom_range(0, 1));
         d_load     = ($urandom_range(0, 2) == 0);
         e_rd       = 4'($urandom_range(0, 7));
         e_wen      = 1'($urandom_range(0, 1));
         e_load     = ($urandom_range(0, 3) == 0);
         m_rd       = 4'($urandom_range(0, 7));
         m_wen      = 1'($urandom_range(0, 1));
         w_rd       = 4'($urandom_range(0, 7));
         w_wen      = 1'($urandom_range(0, 1));
         w_load     = ($urandom_range(0, 2) == 0);
         redirect   = ($urandom_range(0, 15) == 0);
         dmem_req   = ($urandom_range(0, 7) == 0);
         dmem_ready = ($urandom_range(0, 2) != 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
